// File: rtl/synchronous_edge_detector.sv
// Per-lane edge detector: registers the previous input level and flags rising,
// falling and any-edge transitions combinationally against it.
module synchronous_edge_detector #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] previousDataOut,
  output logic [WIDTH-1:0] risingEdge,
  output logic [WIDTH-1:0] fallingEdge,
  output logic [WIDTH-1:0] anyEdge
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  // Next value of the previous-level register; reset wins over capture.
  always_comb begin
    prev_d = prev_q;
    if (reset) begin
      prev_d = RESET_VALUE;
    end else begin
      prev_d = dataIn;
    end
  end

  // Previous-level register, no clock enable.
  always_ff @(posedge clock) begin
    prev_q <= prev_d;
  end

  // Edge flags are zero-latency: they pulse from the input change until prev catches up.
  always_comb begin
    risingEdge  = dataIn & ~prev_q;
    fallingEdge = ~dataIn & prev_q;
    anyEdge     = dataIn ^ prev_q;
  end

  assign previousDataOut = prev_q;

endmodule

// File: tb/tb_synchronous_edge_detector.sv
// Directed bench for synchronous_edge_detector: a 1-lane and a 4-lane instance,
// a per-lane rule model compared every negedge, plus hand-computed expectations.
module tb_synchronous_edge_detector;

  logic       clock;
  logic       reset;
  logic [0:0] din1;
  logic [3:0] din4;
  logic [0:0] prev1, rise1, fall1, any1;
  logic [3:0] prev4, rise4, fall4, any4;

  int checks;
  int failures;

  // Model state: what the previous-value register must hold, per instance.
  logic [0:0] m_prev1;
  logic [3:0] m_prev4;
  logic       model_ok;

  synchronous_edge_detector #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clock           (clock),
    .reset           (reset),
    .dataIn          (din1),
    .previousDataOut (prev1),
    .risingEdge      (rise1),
    .fallingEdge     (fall1),
    .anyEdge         (any1)
  );

  synchronous_edge_detector #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut4 (
    .clock           (clock),
    .reset           (reset),
    .dataIn          (din4),
    .previousDataOut (prev4),
    .risingEdge      (rise4),
    .fallingEdge     (fall4),
    .anyEdge         (any4)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Rule-level expectations: lane by lane, from the textual definitions.
  function automatic logic [3:0] want_rise(input logic [3:0] d, input logic [3:0] p);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (d[i] == 1'b1 && p[i] == 1'b0);
    return r;
  endfunction

  function automatic logic [3:0] want_fall(input logic [3:0] d, input logic [3:0] p);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (d[i] == 1'b0 && p[i] == 1'b1);
    return r;
  endfunction

  function automatic logic [3:0] want_any(input logic [3:0] d, input logic [3:0] p);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (d[i] != p[i]);
    return r;
  endfunction

  // Model register: remembers the input seen at each edge, or the reset value.
  always @(posedge clock) begin
    if (reset) begin
      m_prev1  <= 1'b0;
      m_prev4  <= 4'b0000;
      model_ok <= 1'b1;
    end else begin
      m_prev1 <= din1;
      m_prev4 <= din4;
    end
  end

  // Compare process: every negedge once the model is known.
  always @(negedge clock) begin
    if (model_ok === 1'b1) begin
      chk("m1_prev", {3'b000, prev1}, {3'b000, m_prev1});
      chk("m1_rise", {3'b000, rise1}, want_rise({3'b000, din1}, {3'b000, m_prev1}));
      chk("m1_fall", {3'b000, fall1}, want_fall({3'b000, din1}, {3'b000, m_prev1}));
      chk("m1_any",  {3'b000, any1},  want_any({3'b000, din1}, {3'b000, m_prev1}));
      chk("m4_prev", prev4, m_prev4);
      chk("m4_rise", rise4, want_rise(din4, m_prev4));
      chk("m4_fall", fall4, want_fall(din4, m_prev4));
      chk("m4_any",  any4,  want_any(din4, m_prev4));
    end
  end

  task automatic chk1(input string name, input logic p, input logic r, input logic f, input logic a);
    chk({name, "_prev"}, {3'b000, prev1}, {3'b000, p});
    chk({name, "_rise"}, {3'b000, rise1}, {3'b000, r});
    chk({name, "_fall"}, {3'b000, fall1}, {3'b000, f});
    chk({name, "_any"},  {3'b000, any1},  {3'b000, a});
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_ok = 1'b0;
    reset    = 1'b1;
    din1     = 1'b0;
    din4     = 4'b0000;

    // Settle
    edge1();
    chk1("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) edge1();
    chk1("settle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Rising edge mid-cycle
    #4 din1 = 1'b1;
    #1 chk1("rise_now", 1'b0, 1'b1, 1'b0, 1'b1);
    edge1();
    chk1("rise_e1", 1'b1, 1'b0, 1'b0, 1'b0);
    edge1();
    chk1("rise_e2", 1'b1, 1'b0, 1'b0, 1'b0);

    // Falling edge
    #4 din1 = 1'b0;
    #1 chk1("fall_now", 1'b1, 1'b0, 1'b1, 1'b1);
    edge1();
    chk1("fall_e1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Toggling over consecutive cycles
    #4 din1 = 1'b1;
    #1 chk1("tog_r", 1'b0, 1'b1, 1'b0, 1'b1);
    edge1();
    chk1("tog_e1", 1'b1, 1'b0, 1'b0, 1'b0);
    #4 din1 = 1'b0;
    #1 chk1("tog_f", 1'b1, 1'b0, 1'b1, 1'b1);
    edge1();
    chk1("tog_e2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation overrides capture
    din1 = 1'b1;
    edge1();
    chk1("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    edge1();
    chk1("mid_rst", 1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    edge1();
    chk1("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    // Glitch within one cycle: follows combinationally, nothing latched
    #4 din1 = 1'b0;
    #1 chk1("glitch_lo", 1'b1, 1'b0, 1'b1, 1'b1);
    #1 din1 = 1'b1;
    #1 chk1("glitch_back", 1'b1, 1'b0, 1'b0, 1'b0);
    edge1();
    chk1("glitch_e", 1'b1, 1'b0, 1'b0, 1'b0);

    // Multi-lane
    din4 = 4'b0101;
    edge1();
    chk("ml_prev0", prev4, 4'b0101);
    #4 din4 = 4'b0011;
    #1;
    chk("ml_rise", rise4, 4'b0010);
    chk("ml_fall", fall4, 4'b0100);
    chk("ml_any",  any4,  4'b0110);
    edge1();
    chk("ml_prev1", prev4, 4'b0011);
    chk("ml_any0",  any4,  4'b0000);

    // Pseudo-random lane patterns, checked by the model each negedge
    for (int k = 0; k < 40; k++) begin
      #4;
      din4 = 4'($urandom_range(0, 15));
      din1 = 1'($urandom_range(0, 1));
      edge1();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/synchronous_edge_detector.md
Name: synchronous_edge_detector

Overview:
- Single-clock detector that compares a level input against its value on the previous clock edge.
- Flags rising, falling and any-edge transitions combinationally, in the same cycle the input changes.
- Exposes the registered previous value.
- Used wherever a synchronous signal (strobe, button, status bit) must be turned into one-cycle events. The input must already be synchronous to clock; no metastability synchronizer is included.

Parameters:
- WIDTH, 1, number of independent bit lanes; each lane is detected separately and identically.
- RESET_VALUE, all-zeros (WIDTH bits), value loaded into the previous-value register on reset.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  WIDTH  level signal being monitored.
- previousDataOut  output  WIDTH  registered copy of dataIn from the last rising clock edge.
- risingEdge  output  WIDTH  per lane: dataIn=1 and previousDataOut=0.
- fallingEdge  output  WIDTH  per lane: dataIn=0 and previousDataOut=1.
- anyEdge  output  WIDTH  per lane: dataIn differs from previousDataOut.

Behaviour:
- State: one WIDTH-bit register, prev, driving previousDataOut.
- At each rising clock edge:
  - if reset=1, prev <= RESET_VALUE;
  - otherwise prev <= dataIn.
  - No clock enable.
- Edge outputs are purely combinational from dataIn and prev, with zero latency. They assert as soon as dataIn changes, with no wait for a clock edge:
  - risingEdge = dataIn & ~prev
  - fallingEdge = ~dataIn & prev
  - anyEdge = dataIn ^ prev
- Edge pulse duration:
  - An edge output stays high from the dataIn change until the next rising clock edge.
  - At that edge prev catches up and the output drops.
  - A level held across clock edges produces exactly one pulse, ending at the first clock edge after the change.
- Invariants, at all times and per lane:
  - risingEdge & fallingEdge = 0
  - anyEdge = risingEdge | fallingEdge
- Glitch within a cycle: if dataIn changes and returns before the next clock edge, the edge outputs follow combinationally and prev is unchanged. No event is latched.
- Reset:
  - After a reset clock edge with RESET_VALUE=0, previousDataOut=0 and all edge outputs are 0 while dataIn=0.
  - If dataIn=1 while prev=0, risingEdge=1 and anyEdge=1, including during and immediately after reset.
  - Reset asserted mid-operation overrides the dataIn capture on that edge.
- Reset values:
  - previousDataOut = RESET_VALUE.
  - Edge outputs are not separately reset; they are combinational functions as above.
- Each lane is independent, with no cross-lane interaction.

Decomposition:
- No shared package needed; no typedefs or constants beyond the two parameters.
- No sub-modules: a single register plus three combinational expressions in one module.
- A generate loop per lane is not required; vector operators suffice.

Test Plan (WIDTH=1, clock period 20 ns):
- Settle: apply reset for one edge, then dataIn=0 held over several edges -> previousDataOut=0, risingEdge=0, fallingEdge=0, anyEdge=0.
- Rising edge: dataIn 0->1 mid-cycle.
  - 1 ns later -> previousDataOut=0, risingEdge=1, fallingEdge=0, anyEdge=1.
  - After the next clock edge -> previousDataOut=1, all edges 0.
  - After one more edge -> unchanged.
- Falling edge: from steady 1, dataIn 1->0.
  - Immediately -> previousDataOut=1, fallingEdge=1, anyEdge=1, risingEdge=0.
  - After the next edge -> previousDataOut=0, all edges 0.
- Toggling: dataIn=1, clock edge, then dataIn=0 in the following cycle.
  - After the first change -> risingEdge=1.
  - After the edge -> previousDataOut=1, edges 0.
  - After the second change -> fallingEdge=1, anyEdge=1.
  - After the next edge -> previousDataOut=0, edges 0.
- Reset mid-operation: prev=1, dataIn=1, assert reset for one edge.
  - -> previousDataOut=0, risingEdge=1, anyEdge=1.
  - Deassert reset -> next edge gives previousDataOut=1, edges 0.
- Multi-lane (WIDTH=4): prev=4'b0101, dataIn=4'b0011 -> risingEdge=4'b0010, fallingEdge=4'b0100, anyEdge=4'b0110. Next edge -> previousDataOut=4'b0011.
